// File: rtl/arashi_ctrl_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : arashi_ctrl_sched_port
// Description : One burst port (write or read). Two requesters, round-robin
//               arbitration, one burst at a time, grant held for the burst.
// Ports       : clk, rst   - clock, async active-high reset
//               req[1:0]   - burst request per requester
//               len        - packed burst lengths, LEN_W bits per requester
//               stall      - suppresses beat issue this cycle
//               gnt[1:0]   - registered one-hot grant pulse (first burst cycle)
//               done       - last beat issuing this cycle
//               busy       - port is in BURST
//               beat       - a beat issues this cycle
//               id         - requester owning the port
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module arashi_ctrl_sched_port #(
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [2*LEN_W-1:0] len,
  input  logic               stall,
  output logic [1:0]         gnt,
  output logic               done,
  output logic               busy,
  output logic               beat,
  output logic               id
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             ptr;
  logic             arb;
  logic             winner;

  assign busy = (state == BURST);
  assign beat = busy & ~stall;
  assign done = beat & (cnt == '0);
  // Arbitration happens when idle or while the last beat is issuing, so a
  // new burst follows back-to-back with no idle bubble.
  assign arb  = (state == IDLE) | done;

  // Single request wins outright; contention is resolved by the rr pointer.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ptr;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 1'b0;
      id    <= 1'b0;
      gnt   <= 2'b00;
    end else if (arb) begin
      if (|req) begin
        state <= BURST;
        id    <= winner;
        cnt   <= winner ? len[2*LEN_W-1:LEN_W] : len[LEN_W-1:0];
        ptr   <= ~winner;
        gnt   <= {winner, ~winner};
      end else begin
        state <= IDLE;
        gnt   <= 2'b00;
      end
    end else begin
      gnt <= 2'b00;
      // cnt only moves on an issued beat; stall freezes the burst.
      if (beat) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

//------------------------------------------------------------------------------
// Module      : arashi_ctrl_sched
// Description : Burst scheduler producing the 4-bit ctrl word for
//               arashi_ctrl_decoder. Independent write and read ports.
// Ports       : clk, rst                 - clock, async active-high reset
//               w_req/w_len/w_gnt/w_done/w_busy - write port
//               r_req/r_len/r_gnt/r_done/r_busy - read port
//               stall                    - suppresses beats on both ports
//               ctrl[3:0]                - {w_id, r_id, w_ena, r_ena}
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module arashi_ctrl_sched #(
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         w_req,
  input  logic [2*LEN_W-1:0] w_len,
  output logic [1:0]         w_gnt,
  output logic               w_done,
  output logic               w_busy,
  input  logic [1:0]         r_req,
  input  logic [2*LEN_W-1:0] r_len,
  output logic [1:0]         r_gnt,
  output logic               r_done,
  output logic               r_busy,
  input  logic               stall,
  output logic [3:0]         ctrl
);

  logic w_beat, w_id, r_beat, r_id;

  arashi_ctrl_sched_port #(.LEN_W(LEN_W)) u_wr (
    .clk  (clk),
    .rst  (rst),
    .req  (w_req),
    .len  (w_len),
    .stall(stall),
    .gnt  (w_gnt),
    .done (w_done),
    .busy (w_busy),
    .beat (w_beat),
    .id   (w_id)
  );

  arashi_ctrl_sched_port #(.LEN_W(LEN_W)) u_rd (
    .clk  (clk),
    .rst  (rst),
    .req  (r_req),
    .len  (r_len),
    .stall(stall),
    .gnt  (r_gnt),
    .done (r_done),
    .busy (r_busy),
    .beat (r_beat),
    .id   (r_id)
  );

  // id bits are gated by their beat so ctrl is all-zero with no beat.
  assign ctrl = {w_id & w_beat, r_id & r_beat, w_beat, r_beat};

endmodule
`default_nettype wire

// File: tb/tb_arashi_ctrl_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_arashi_ctrl_sched
// Description : Table-driven bench for arashi_ctrl_sched. Each record holds
//               one cycle of inputs and the expected outputs for that cycle.
//               Expectations are queued as inputs are driven and popped when
//               outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_arashi_ctrl_sched;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       w_req = '0, r_req = '0;
  logic [2*LEN_W-1:0] w_len = '0, r_len = '0;
  logic             stall = 1'b0;
  logic [1:0]       w_gnt, r_gnt;
  logic             w_done, w_busy, r_done, r_busy;
  logic [3:0]       ctrl;

  arashi_ctrl_sched #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .w_req (w_req),
    .w_len (w_len),
    .w_gnt (w_gnt),
    .w_done(w_done),
    .w_busy(w_busy),
    .r_req (r_req),
    .r_len (r_len),
    .r_gnt (r_gnt),
    .r_done(r_done),
    .r_busy(r_busy),
    .stall (stall),
    .ctrl  (ctrl)
  );

  always #5 clk = ~clk;

  // exp = {ctrl[3:0], w_gnt[1:0], w_done, w_busy, r_gnt[1:0], r_done, r_busy}
  typedef struct {
    logic        rst;
    logic [1:0]  w_req;
    logic [7:0]  w_len;
    logic [1:0]  r_req;
    logic [7:0]  r_len;
    logic        stall;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    int          idx;
    logic [11:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(input logic rs, input logic [1:0] wq, input logic [7:0] wl,
                              input logic [1:0] rq, input logic [7:0] rl, input logic st,
                              input logic [3:0] c, input logic [1:0] wg, input logic wd,
                              input logic wb, input logic [1:0] rg, input logic rd,
                              input logic rb);
    vec_t v;
    v.rst = rs; v.w_req = wq; v.w_len = wl; v.r_req = rq; v.r_len = rl; v.stall = st;
    v.exp = {c, wg, wd, wb, rg, rd, rb};
    vecs.push_back(v);
  endfunction

  // Sample away from the driving edge and check against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      logic [11:0] got;
      e   = sb.pop_front();
      got = {ctrl, w_gnt, w_done, w_busy, r_gnt, r_done, r_busy};
      n_cmp++;
      if (got !== e.exp) begin
        n_err++;
        $display("FAIL vec%0d {ctrl,wg,wd,wb,rg,rd,rb}: got %b_%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b_%b",
                 e.idx, got[11:8], got[7:6], got[5], got[4], got[3:2], got[1], got[0],
                 e.exp[11:8], e.exp[7:6], e.exp[5], e.exp[4], e.exp[3:2], e.exp[1], e.exp[0]);
      end
    end
  end

  initial begin
    // T1: single write, len 2 -> 3 beats, done on third
    add(1,0,0,0,0,0, 4'b0000,0,0,0, 0,0,0);
    add(0,1,8'h02,0,0,0, 4'b0000,0,0,0, 0,0,0);
    add(0,0,8'h02,0,0,0, 4'b0010,2'b01,0,1, 0,0,0);
    add(0,0,8'h02,0,0,0, 4'b0010,0,0,1, 0,0,0);
    add(0,0,8'h02,0,0,0, 4'b0010,0,1,1, 0,0,0);
    add(0,0,0,0,0,0,     4'b0000,0,0,0, 0,0,0);
    // T2: both request, lens 1 -> id0 then id1 back-to-back
    add(1,0,0,0,0,0,      4'b0000,0,0,0, 0,0,0);
    add(0,2'b11,8'h11,0,0,0, 4'b0000,0,0,0, 0,0,0);
    add(0,2'b10,8'h11,0,0,0, 4'b0010,2'b01,0,1, 0,0,0);
    add(0,2'b10,8'h11,0,0,0, 4'b0010,0,1,1, 0,0,0);
    add(0,2'b00,8'h11,0,0,0, 4'b1010,2'b10,0,1, 0,0,0);
    add(0,2'b00,8'h11,0,0,0, 4'b1010,0,1,1, 0,0,0);
    add(0,0,0,0,0,0,         4'b0000,0,0,0, 0,0,0);
    // T3: concurrent write id0 len1 and read id1 len0
    add(1,0,0,0,0,0,          4'b0000,0,0,0, 0,0,0);
    add(0,2'b01,8'h01,2'b10,8'h00,0, 4'b0000,0,0,0, 0,0,0);
    add(0,0,8'h01,0,0,0,      4'b0111,2'b01,0,1, 2'b10,1,1);
    add(0,0,8'h01,0,0,0,      4'b0010,0,1,1, 0,0,0);
    add(0,0,0,0,0,0,          4'b0000,0,0,0, 0,0,0);
    // T4: 4-beat write with 2 stall cycles; len changes mid-burst are ignored
    add(1,0,0,0,0,0,     4'b0000,0,0,0, 0,0,0);
    add(0,1,8'h03,0,0,0, 4'b0000,0,0,0, 0,0,0);
    add(0,0,8'h03,0,0,0, 4'b0010,2'b01,0,1, 0,0,0);
    add(0,0,8'h00,0,0,1, 4'b0000,0,0,1, 0,0,0);
    add(0,0,8'h00,0,0,1, 4'b0000,0,0,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 4'b0010,0,0,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 4'b0010,0,0,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 4'b0010,0,1,1, 0,0,0);
    add(0,0,0,0,0,0,     4'b0000,0,0,0, 0,0,0);
    // T5: reset on beat 2 of 4; pointer restarts at 0
    add(1,0,0,0,0,0,     4'b0000,0,0,0, 0,0,0);
    add(0,1,8'h03,0,0,0, 4'b0000,0,0,0, 0,0,0);
    add(0,0,8'h03,0,0,0, 4'b0010,2'b01,0,1, 0,0,0);
    add(1,0,8'h03,0,0,0, 4'b0000,0,0,0, 0,0,0);
    add(0,2'b11,8'h00,0,0,0, 4'b0000,0,0,0, 0,0,0);
    add(0,2'b10,8'h00,0,0,0, 4'b0010,2'b01,1,1, 0,0,0);
    add(0,2'b00,8'h00,0,0,0, 4'b1010,2'b10,1,1, 0,0,0);
    add(0,0,0,0,0,0,     4'b0000,0,0,0, 0,0,0);
    // T6: maximum length -> 16 beats, single done
    add(1,0,0,0,0,0,     4'b0000,0,0,0, 0,0,0);
    add(0,1,8'h0F,0,0,0, 4'b0000,0,0,0, 0,0,0);
    for (int k = 0; k < 16; k++)
      add(0,0,8'h0F,0,0,0, 4'b0010, (k == 0) ? 2'b01 : 2'b00, (k == 15), 1, 0,0,0);
    add(0,0,0,0,0,0,     4'b0000,0,0,0, 0,0,0);
    add(0,0,0,0,0,0,     4'b0000,0,0,0, 0,0,0);
    // T7: req held through the grant cycle re-competes
    add(1,0,0,0,0,0,     4'b0000,0,0,0, 0,0,0);
    add(0,1,8'h00,0,0,0, 4'b0000,0,0,0, 0,0,0);
    add(0,1,8'h00,0,0,0, 4'b0010,2'b01,1,1, 0,0,0);
    add(0,0,8'h00,0,0,0, 4'b0010,2'b01,1,1, 0,0,0);
    add(0,0,0,0,0,0,     4'b0000,0,0,0, 0,0,0);
    // T8: read-port round robin, lens 0
    add(1,0,0,0,0,0,           4'b0000,0,0,0, 0,0,0);
    add(0,0,0,2'b11,8'h00,0,   4'b0000,0,0,0, 0,0,0);
    add(0,0,0,2'b10,8'h00,0,   4'b0001,0,0,0, 2'b01,1,1);
    add(0,0,0,2'b00,8'h00,0,   4'b0101,0,0,0, 2'b10,1,1);
    add(0,0,0,0,0,0,           4'b0000,0,0,0, 0,0,0);
    // T9: id1 on both ports at once -> 1111
    add(1,0,0,0,0,0,                 4'b0000,0,0,0, 0,0,0);
    add(0,2'b10,8'h00,2'b10,8'h00,0, 4'b0000,0,0,0, 0,0,0);
    add(0,0,0,0,0,0,                 4'b1111,2'b10,1,1, 2'b10,1,1);
    add(0,0,0,0,0,0,                 4'b0000,0,0,0, 0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      sb_t e;
      @(posedge clk);
      #1;
      rst   = vecs[i].rst;
      w_req = vecs[i].w_req;
      w_len = vecs[i].w_len;
      r_req = vecs[i].r_req;
      r_len = vecs[i].r_len;
      stall = vecs[i].stall;
      e.idx = i;
      e.exp = vecs[i].exp;
      sb.push_back(e);
    end

    // Bounded drain of outstanding expectations.
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
